// File: rtl/ariane_pkg.sv
// Slice of the core package: the frontend-to-decode fetch record and the
// default depth of the fetch buffer that sits between them.
package ariane_pkg;

    localparam int unsigned FETCH_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] instruction;
        logic        bp_taken;
        logic        page_fault;
    } frontend_fetch_t;

endpackage

// File: rtl/fetch_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the fetch buffer: qualifies push and pop,
// tracks count, and clears everything on flush.
module fifo_ctrl #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_req_i,
    input  logic             pop_req_i,
    output logic             push_o,
    output logic             pop_o,
    output logic             ready_o,
    output logic             valid_o,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] rptr_o,
    output logic [PTR_W:0]   usage_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   cnt_q;

    // Ready depends only on stored count, so a full FIFO refuses a push even
    // in a cycle where decode pops; this keeps ack off the ready path.
    assign ready_o = (cnt_q != FULL_CNT);
    assign valid_o = (cnt_q != '0);
    assign push_o  = push_req_i && ready_o && !flush_i;
    assign pop_o   = pop_req_i && valid_o && !flush_i;
    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign usage_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_o) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_o)  rptr_q <= rptr_q + PTR_W'(1);
            case ({push_o, pop_o})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_q <= FULL_CNT);
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop_req_i |-> valid_o);

endmodule

// File: rtl/fetch_fifo.sv
// Decoupling buffer between frontend and decode; owns the entry storage and
// leaves pointer/count handling to fifo_ctrl.
module fetch_fifo
    import ariane_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_FIFO_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  frontend_fetch_t fetch_entry_i,
    input  logic            fetch_entry_valid_i,
    output logic            fetch_entry_ready_o,
    output frontend_fetch_t fetch_entry_o,
    output logic            fetch_entry_valid_o,
    input  logic            fetch_ack_i,
    output logic [PTR_W:0]  usage_o
);

    logic             push, pop;
    logic [PTR_W-1:0] wptr, rptr;

    frontend_fetch_t [DEPTH-1:0] mem_q;

    fifo_ctrl #(.DEPTH(DEPTH)) i_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .push_req_i (fetch_entry_valid_i),
        .pop_req_i  (fetch_ack_i),
        .push_o     (push),
        .pop_o      (pop),
        .ready_o    (fetch_entry_ready_o),
        .valid_o    (fetch_entry_valid_o),
        .wptr_o     (wptr),
        .rptr_o     (rptr),
        .usage_o    (usage_o)
    );

    // Storage carries no reset; the head is only meaningful while valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr] <= fetch_entry_i;
    end

    assign fetch_entry_o = mem_q[rptr];

    a_entry_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fetch_entry_valid_i && !fetch_entry_ready_o && !flush_i) |=> $stable(fetch_entry_i));

endmodule

// File: tb/tb_fetch_fifo.sv
// Randomized and directed bench for fetch_fifo against a queue-based model.
module tb_fetch_fifo;
    import ariane_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    frontend_fetch_t fetch_entry_i;
    logic            fetch_entry_valid_i;
    logic            fetch_entry_ready_o;
    frontend_fetch_t fetch_entry_o;
    logic            fetch_entry_valid_o;
    logic            fetch_ack_i;
    logic [PTR_W:0]  usage_o;

    int n_cmp = 0;
    int n_err = 0;
    frontend_fetch_t q[$];

    fetch_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_ack_i         (fetch_ack_i),
        .usage_o             (usage_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frontend_fetch_t mk(input logic [63:0] a);
        frontend_fetch_t e;
        e.address     = a;
        e.instruction = $urandom;
        e.bp_taken    = 1'($urandom);
        e.page_fault  = 1'($urandom);
        return e;
    endfunction

    // One cycle: drive, compare outputs against the model, advance the model.
    task automatic step(input logic v, input frontend_fetch_t e, input logic ack,
                        input logic fl, output logic acc);
        logic do_push, do_pop;
        fetch_entry_valid_i = v;
        fetch_entry_i       = e;
        fetch_ack_i         = ack;
        flush_i             = fl;
        #2;
        chk("valid_o", 128'(fetch_entry_valid_o), 128'(q.size() != 0));
        chk("ready_o", 128'(fetch_entry_ready_o), 128'(q.size() != DEPTH));
        chk("usage_o", 128'(usage_o), 128'(q.size()));
        if (q.size() != 0) chk("entry_o", 128'(fetch_entry_o), 128'(q[0]));
        do_push = v && (q.size() < DEPTH) && !fl;
        do_pop  = ack && (q.size() != 0) && !fl;
        if (fl) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        acc = do_push;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        frontend_fetch_t e, held, pend_e;
        logic acc, pend_v, ack_r, fl_r;

        rst_ni = 1'b0; flush_i = 1'b0; fetch_entry_valid_i = 1'b0;
        fetch_ack_i = 1'b0; fetch_entry_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 128'(fetch_entry_valid_o), 128'(0));
        chk("rst_ready", 128'(fetch_entry_ready_o), 128'(1));
        chk("rst_usage", 128'(usage_o), 128'(0));
        #4 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // single entry
        step(1'b1, mk(64'h8000_0000), 1'b0, 1'b0, acc);
        chk("single_addr", 128'(fetch_entry_o.address), 128'(64'h8000_0000));
        step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);

        // fill to full, fifth offer held off until the first ack frees a slot
        for (int k = 0; k < 4; k++) step(1'b1, mk(64'h100 + 64'(4*k)), 1'b0, 1'b0, acc);
        held = mk(64'h110);
        step(1'b1, held, 1'b0, 1'b0, acc);
        chk("full_refuse", 128'(acc), 128'(0));
        step(1'b1, held, 1'b1, 1'b0, acc);
        chk("full_pop_refuse", 128'(acc), 128'(0));
        step(1'b1, held, 1'b1, 1'b0, acc);
        chk("accept_after_ack", 128'(acc), 128'(1));
        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);

        // full with simultaneous push/ack
        for (int k = 0; k < 4; k++) step(1'b1, mk(64'h180 + 64'(4*k)), 1'b0, 1'b0, acc);
        held = mk(64'h1C0);
        step(1'b1, held, 1'b1, 1'b0, acc);
        step(1'b1, held, 1'b1, 1'b0, acc);
        chk("pushpop_usage3", 128'(usage_o), 128'(3));
        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, acc);

        // wrap-around stream
        for (int k = 0; k < 10; k++) begin
            step(1'b1, mk(64'h200 + 64'(4*k)), k > 0, 1'b0, acc);
            chk("wrap_usage_le2", 128'(usage_o <= 2), 128'(1));
        end
        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, acc);

        // flush with same-cycle push
        for (int k = 0; k < 3; k++) step(1'b1, mk(64'h280 + 64'(4*k)), 1'b0, 1'b0, acc);
        step(1'b1, mk(64'h300), 1'b0, 1'b1, acc);
        chk("flush_usage", 128'(usage_o), 128'(0));
        step(1'b1, mk(64'h400), 1'b0, 1'b0, acc);
        chk("post_flush_addr", 128'(fetch_entry_o.address), 128'(64'h400));
        step(1'b0, '0, 1'b1, 1'b0, acc);

        // async reset mid-cycle at count 2
        step(1'b1, mk(64'h500), 1'b0, 1'b0, acc);
        step(1'b1, mk(64'h504), 1'b0, 1'b0, acc);
        fetch_entry_valid_i = 1'b0;
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 128'(fetch_entry_valid_o), 128'(0));
        chk("arst_ready", 128'(fetch_entry_ready_o), 128'(1));
        chk("arst_usage", 128'(usage_o), 128'(0));
        q.delete();
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        step(1'b1, mk(64'hA00), 1'b0, 1'b0, acc);
        chk("arst_first_addr", 128'(fetch_entry_o.address), 128'(64'hA00));
        step(1'b0, '0, 1'b1, 1'b0, acc);

        // randomized traffic; ack pressure varies per phase to reach full and empty
        pend_v = 1'b0;
        pend_e = '0;
        for (int c = 0; c < 1600; c++) begin
            if (!pend_v && $urandom_range(3) != 0) begin
                pend_v = 1'b1;
                pend_e = mk({$urandom, $urandom});
            end
            ack_r = ($urandom_range(3) < 32'((c / 200) % 4)) && (q.size() != 0);
            fl_r  = ($urandom_range(39) == 0);
            step(pend_v, pend_e, ack_r, fl_r, acc);
            if (acc || fl_r) pend_v = 1'b0;
        end
        while (q.size() != 0) step(1'b0, '0, 1'b1, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
